seven_segment_scanner: RTL

Multiplexed display controller that feeds the one-hot digit decoder and drives the digit anodes. It holds NUM_DIGITS BCD digits and time-slices them at a fixed refresh rate. Each slot emits the one-hot 10-bit code of the selected digit and the active-low anode pattern. New display words arrive through a valid/ready handshake and are committed only at frame boundaries, so the display never tears.

---
 rtl/seven_segment_scanner.sv | 112 +++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed BCD display scanner with a frame-synchronous double-buffered word
// and a valid/ready write port; emits one-hot digit codes and active-low anodes.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          blank_lz,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [4*NUM_DIGITS-1:0]       wr_data,
  output logic [9:0]                    digit_onehot,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick,
  output logic                          bcd_err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           index;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;
  logic                    err_q;

  logic                    slot_end;
  logic                    tick;
  logic                    wr_fire;
  logic                    word_err;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur;
  logic                    cur_blank;

  assign slot_end   = enable && (prescaler == PRE_LAST);
  assign tick       = slot_end && (index == IDX_LAST);
  assign wr_ready   = ~pending;
  assign wr_fire    = wr_valid & ~pending;
  assign digit_idx  = index;
  assign frame_tick = tick;
  assign bcd_err    = err_q;

  always_comb begin
    word_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_data[i*4 +: 4] > 4'd9) word_err = 1'b1;
    end
  end

  // lead_zero[i] is set when digit i and every digit above it are zero
  always_comb begin
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (active[i*4 +: 4] == 4'd0);
      lead_zero[i] = all_zero;
    end
  end

  assign cur       = active[{index, 2'b00} +: 4];
  assign cur_blank = (cur > 4'd9) || (blank_lz && (index != '0) && lead_zero[index]);

  always_comb begin
    anode_n      = '1;
    digit_onehot = '0;
    if (enable) begin
      anode_n = ~(NUM_DIGITS'(1) << index);
      if (!cur_blank) digit_onehot = 10'(1) << cur;
    end
  end

  // Commit and accept are exclusive because both key off the registered pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      index     <= '0;
      active    <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (enable) begin
        if (slot_end) begin
          prescaler <= '0;
          index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end else begin
        prescaler <= '0;
        index     <= '0;
      end

      if (pending && (!enable || tick)) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (wr_fire) begin
        shadow  <= wr_data;
        pending <= 1'b1;
        err_q   <= word_err;
      end
    end
  end

endmodule
